// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester, controller and status signals around the shared memory port.
// The arbiter uses the slave modport; the requester/controller environment uses master.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_ack;
    logic [DATA_W-1:0] if_rdata;
    logic              if_stall;

    logic              mem_req;
    logic              mem_wr;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_stall;

    logic              ctl_work;
    logic              ctl_rd;
    logic              ctl_wr;
    logic [ADDR_W-1:0] ctl_addr;
    logic [DATA_W-1:0] ctl_value;
    logic              ctl_done;
    logic [DATA_W-1:0] ctl_result;

    logic              tmo_err;

    modport slave (
        input  if_req, if_addr, mem_req, mem_wr, mem_addr, mem_wdata, ctl_done, ctl_result,
        output if_ack, if_rdata, if_stall, mem_ack, mem_rdata, mem_stall,
               ctl_work, ctl_rd, ctl_wr, ctl_addr, ctl_value, tmo_err
    );

    modport master (
        output if_req, if_addr, mem_req, mem_wr, mem_addr, mem_wdata, ctl_done, ctl_result,
        input  if_ack, if_rdata, if_stall, mem_ack, mem_rdata, mem_stall,
               ctl_work, ctl_rd, ctl_wr, ctl_addr, ctl_value, tmo_err
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single RAM1/UART controller port between instruction fetch and load/store,
// with MEM priority, level-done tracking, pipeline stalls and a hang watchdog.
module mem_port_arbiter #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 16,
    parameter int TMO_CYCLES = 4095,
    parameter int TMO_W      = 12
) (
    input logic              clk,
    input logic              rst,
    mem_port_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACCEPT, BUSY, RESP} state_e;
    typedef enum logic {OWN_IF, OWN_MEM} owner_e;

    state_e            state_q, state_d;
    owner_e            owner_q, owner_d;
    logic              op_wr_q, op_wr_d;
    logic [TMO_W-1:0]  tmo_cnt_q, tmo_cnt_d;
    logic              tmo_err_q, tmo_err_d;
    logic              ctl_work_q, ctl_work_d;
    logic              ctl_rd_q, ctl_rd_d;
    logic              ctl_wr_q, ctl_wr_d;
    logic [ADDR_W-1:0] ctl_addr_q, ctl_addr_d;
    logic [DATA_W-1:0] ctl_value_q, ctl_value_d;
    logic              if_ack_q, if_ack_d;
    logic              mem_ack_q, mem_ack_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;

    logic              active;
    logic              tmo_hit;
    logic              done_ok;
    logic [DATA_W-1:0] resp_data;

    assign active  = (state_q == ACCEPT) || (state_q == BUSY);
    assign tmo_hit = active && (tmo_cnt_q == TMO_W'(TMO_CYCLES - 1));
    // A completion seen in the same cycle as the watchdog expiry still counts as success.
    assign done_ok = (state_q == BUSY) && bus.ctl_done;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.mem_req || bus.if_req) state_d = ACCEPT;
            ACCEPT:  if (tmo_hit) state_d = RESP;
                     else if (!bus.ctl_done) state_d = BUSY;
            BUSY:    if (bus.ctl_done || tmo_hit) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        owner_d     = owner_q;
        op_wr_d     = op_wr_q;
        ctl_addr_d  = ctl_addr_q;
        ctl_value_d = ctl_value_q;
        tmo_cnt_d   = tmo_cnt_q;
        tmo_err_d   = tmo_err_q;
        if_rdata_d  = if_rdata_q;
        mem_rdata_d = mem_rdata_q;
        resp_data   = '0;

        if (state_q == IDLE) begin
            tmo_cnt_d = '0;
            if (bus.mem_req) begin
                owner_d     = OWN_MEM;
                op_wr_d     = bus.mem_wr;
                ctl_addr_d  = bus.mem_addr;
                ctl_value_d = bus.mem_wdata;
            end else if (bus.if_req) begin
                owner_d     = OWN_IF;
                op_wr_d     = 1'b0;
                ctl_addr_d  = bus.if_addr;
                ctl_value_d = '0;
            end
        end

        if (active) tmo_cnt_d = tmo_cnt_q + 1'b1;

        // Leaving ACCEPT/BUSY: either a real completion or a watchdog abort returning all ones.
        if (active && state_d == RESP) begin
            if (done_ok) resp_data = op_wr_q ? '0 : bus.ctl_result;
            else         resp_data = '1;
            tmo_err_d = tmo_err_q | ~done_ok;
            if (owner_q == OWN_MEM) mem_rdata_d = resp_data;
            else                    if_rdata_d  = resp_data;
        end

        ctl_work_d = (state_d == ACCEPT) || (state_d == BUSY);
        ctl_rd_d   = ctl_work_d && !op_wr_d;
        ctl_wr_d   = ctl_work_d && op_wr_d;
        if_ack_d   = (state_d == RESP) && (owner_d == OWN_IF);
        mem_ack_d  = (state_d == RESP) && (owner_d == OWN_MEM);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            owner_q     <= OWN_IF;
            op_wr_q     <= 1'b0;
            tmo_cnt_q   <= '0;
            tmo_err_q   <= 1'b0;
            ctl_work_q  <= 1'b0;
            ctl_rd_q    <= 1'b0;
            ctl_wr_q    <= 1'b0;
            ctl_addr_q  <= '0;
            ctl_value_q <= '0;
            if_ack_q    <= 1'b0;
            mem_ack_q   <= 1'b0;
            if_rdata_q  <= '0;
            mem_rdata_q <= '0;
        end else begin
            owner_q     <= owner_d;
            op_wr_q     <= op_wr_d;
            tmo_cnt_q   <= tmo_cnt_d;
            tmo_err_q   <= tmo_err_d;
            ctl_work_q  <= ctl_work_d;
            ctl_rd_q    <= ctl_rd_d;
            ctl_wr_q    <= ctl_wr_d;
            ctl_addr_q  <= ctl_addr_d;
            ctl_value_q <= ctl_value_d;
            if_ack_q    <= if_ack_d;
            mem_ack_q   <= mem_ack_d;
            if_rdata_q  <= if_rdata_d;
            mem_rdata_q <= mem_rdata_d;
        end
    end

    assign bus.ctl_work  = ctl_work_q;
    assign bus.ctl_rd    = ctl_rd_q;
    assign bus.ctl_wr    = ctl_wr_q;
    assign bus.ctl_addr  = ctl_addr_q;
    assign bus.ctl_value = ctl_value_q;
    assign bus.if_ack    = if_ack_q;
    assign bus.mem_ack   = mem_ack_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.mem_rdata = mem_rdata_q;
    assign bus.tmo_err   = tmo_err_q;
    assign bus.if_stall  = bus.if_req && !if_ack_q;
    assign bus.mem_stall = bus.mem_req && !mem_ack_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: drives requesters and a scripted controller,
// checks acks, data, strobes, stalls, watchdog and reset against hand-computed values.
module tb_mem_port_arbiter;
    logic clk;
    logic rst;
    int   n_total = 0;
    int   n_pass  = 0;
    int   n_fail  = 0;

    mem_port_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus ();

    mem_port_arbiter #(
        .ADDR_W(16), .DATA_W(16), .TMO_CYCLES(20), .TMO_W(12)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scripted controller: keeps done high for fall_dly cycles after work appears, holds it
    // low for rise_dly cycles, then presents res with done high. Returns at the RESP sample.
    task automatic run_ctl(input int fall_dly, input int rise_dly, input logic [15:0] res,
                           input logic exp_wr, input logic [15:0] exp_addr,
                           input logic [15:0] exp_val);
        int n = 0;
        bit early = 1'b0;
        bit bad = 1'b0;
        while (bus.ctl_work !== 1'b1 && n < 8) begin
            step();
            n++;
        end
        check("work_seen", bus.ctl_work, 1);
        check("ctl_addr", bus.ctl_addr, exp_addr);
        if (exp_wr) check("ctl_value", bus.ctl_value, exp_val);
        if (bus.ctl_rd !== !exp_wr || bus.ctl_wr !== exp_wr) bad = 1'b1;
        repeat (fall_dly) begin
            step();
            if (bus.if_ack !== 1'b0 || bus.mem_ack !== 1'b0 || bus.ctl_work !== 1'b1) early = 1'b1;
        end
        bus.ctl_done = 1'b0;
        repeat (rise_dly) begin
            step();
            if (bus.if_ack !== 1'b0 || bus.mem_ack !== 1'b0) early = 1'b1;
            if (bus.ctl_work !== 1'b1 || bus.ctl_rd !== !exp_wr || bus.ctl_wr !== exp_wr) bad = 1'b1;
        end
        check("no_early_ack", early, 0);
        check("ctl_strobes", bad, 0);
        bus.ctl_result = res;
        bus.ctl_done   = 1'b1;
        step();
    endtask

    initial begin
        int n;
        rst            = 1'b1;
        bus.if_req     = 1'b0;
        bus.if_addr    = '0;
        bus.mem_req    = 1'b0;
        bus.mem_wr     = 1'b0;
        bus.mem_addr   = '0;
        bus.mem_wdata  = '0;
        bus.ctl_done   = 1'b1;
        bus.ctl_result = '0;
        step();
        step();

        // Reset state
        check("rst_ctl_work", bus.ctl_work, 0);
        check("rst_ctl_rd", bus.ctl_rd, 0);
        check("rst_ctl_wr", bus.ctl_wr, 0);
        check("rst_if_ack", bus.if_ack, 0);
        check("rst_mem_ack", bus.mem_ack, 0);
        check("rst_tmo_err", bus.tmo_err, 0);
        check("rst_ctl_addr", bus.ctl_addr, 0);
        rst = 1'b0;

        // IF read 0x0040 -> 0x1234 after 5 cycles
        bus.if_req  = 1'b1;
        bus.if_addr = 16'h0040;
        #1;
        check("if_stall_pending", bus.if_stall, 1);
        run_ctl(0, 5, 16'h1234, 1'b0, 16'h0040, 16'h0000);
        check("if_ack", bus.if_ack, 1);
        check("if_rdata", bus.if_rdata, 16'h1234);
        check("if_stall_falls", bus.if_stall, 0);
        check("if_no_mem_ack", bus.mem_ack, 0);
        check("resp_work_low", bus.ctl_work, 0);
        bus.if_req = 1'b0;
        step();
        check("if_ack_one_cycle", bus.if_ack, 0);

        // MEM write 0x0041 to UART 0xBF00; result bus carries junk that must not leak
        bus.mem_req   = 1'b1;
        bus.mem_wr    = 1'b1;
        bus.mem_addr  = 16'hBF00;
        bus.mem_wdata = 16'h0041;
        #1;
        check("mem_stall_pending", bus.mem_stall, 1);
        run_ctl(0, 3, 16'hAAAA, 1'b1, 16'hBF00, 16'h0041);
        check("wr_mem_ack", bus.mem_ack, 1);
        check("wr_mem_rdata", bus.mem_rdata, 16'h0000);
        check("wr_no_if_ack", bus.if_ack, 0);
        check("wr_mem_stall", bus.mem_stall, 0);
        bus.mem_req = 1'b0;
        bus.mem_wr  = 1'b0;
        step();
        check("wr_work_after", bus.ctl_work, 0);
        check("wr_ack_one_cycle", bus.mem_ack, 0);

        // Simultaneous IF and MEM: MEM read 0x8000 first, then IF 0x0100
        bus.if_req   = 1'b1;
        bus.if_addr  = 16'h0100;
        bus.mem_req  = 1'b1;
        bus.mem_addr = 16'h8000;
        run_ctl(0, 2, 16'hBEEF, 1'b0, 16'h8000, 16'h0000);
        check("sim_mem_ack", bus.mem_ack, 1);
        check("sim_mem_rdata", bus.mem_rdata, 16'hBEEF);
        check("sim_if_wait", bus.if_ack, 0);
        check("sim_if_stall_resp", bus.if_stall, 1);
        bus.mem_req = 1'b0;
        step();
        check("sim_idle_work", bus.ctl_work, 0);
        check("sim_if_stall_idle", bus.if_stall, 1);
        run_ctl(0, 2, 16'h5678, 1'b0, 16'h0100, 16'h0000);
        check("sim_if_ack", bus.if_ack, 1);
        check("sim_if_rdata", bus.if_rdata, 16'h5678);
        check("sim_if_stall_end", bus.if_stall, 0);
        check("sim_mem_rdata_kept", bus.mem_rdata, 16'hBEEF);
        bus.if_req = 1'b0;
        step();

        // Stale done: done stays high 3 cycles into the access before falling
        bus.if_req  = 1'b1;
        bus.if_addr = 16'h0200;
        run_ctl(3, 4, 16'h4321, 1'b0, 16'h0200, 16'h0000);
        check("stale_if_ack", bus.if_ack, 1);
        check("stale_if_rdata", bus.if_rdata, 16'h4321);
        bus.if_req = 1'b0;
        step();

        // Timeout: done falls but never rises
        bus.mem_req  = 1'b1;
        bus.mem_wr   = 1'b0;
        bus.mem_addr = 16'h0300;
        step();
        n = 0;
        while (bus.ctl_work === 1'b1 && n < 40) begin
            n++;
            bus.ctl_done = 1'b0;
            step();
        end
        check("tmo_cycles", n, 20);
        check("tmo_err_set", bus.tmo_err, 1);
        check("tmo_mem_ack", bus.mem_ack, 1);
        check("tmo_mem_rdata", bus.mem_rdata, 16'hFFFF);
        bus.mem_req  = 1'b0;
        bus.ctl_done = 1'b1;
        step();
        check("tmo_err_sticky", bus.tmo_err, 1);
        check("tmo_ack_one_cycle", bus.mem_ack, 0);

        // Normal service after a timeout
        bus.if_req  = 1'b1;
        bus.if_addr = 16'h0400;
        run_ctl(0, 2, 16'h2222, 1'b0, 16'h0400, 16'h0000);
        check("post_tmo_if_ack", bus.if_ack, 1);
        check("post_tmo_if_rdata", bus.if_rdata, 16'h2222);
        check("post_tmo_err", bus.tmo_err, 1);
        bus.if_req = 1'b0;
        step();

        // Reset while BUSY with the MEM request held throughout
        bus.mem_req  = 1'b1;
        bus.mem_wr   = 1'b0;
        bus.mem_addr = 16'h0500;
        step();
        check("rb_accept_work", bus.ctl_work, 1);
        bus.ctl_done = 1'b0;
        step();
        check("rb_busy_work", bus.ctl_work, 1);
        rst = 1'b1;
        step();
        check("rb_work", bus.ctl_work, 0);
        check("rb_rd", bus.ctl_rd, 0);
        check("rb_mem_ack", bus.mem_ack, 0);
        check("rb_if_ack", bus.if_ack, 0);
        check("rb_if_rdata", bus.if_rdata, 0);
        check("rb_tmo_err", bus.tmo_err, 0);
        check("rb_ctl_addr", bus.ctl_addr, 0);
        check("rb_mem_stall", bus.mem_stall, 1);
        rst          = 1'b0;
        bus.ctl_done = 1'b1;
        run_ctl(0, 2, 16'h3333, 1'b0, 16'h0500, 16'h0000);
        check("rb_regrant_ack", bus.mem_ack, 1);
        check("rb_regrant_rdata", bus.mem_rdata, 16'h3333);
        bus.mem_req = 1'b0;
        step();
        check("rb_final_idle", bus.ctl_work, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
